// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame format and a
// frame-length helper, common to transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_PARITY_EN    = 1;
    localparam int UART_PARITY_ODD   = 0;
    localparam int UART_STOP_BITS    = 1;

    // Whole frame in clk_uart cycles; int holds the worst case (12 * 65535).
    function automatic int uart_frame_len(input int clks_per_bit,
                                          input int data_bits,
                                          input int parity_en,
                                          input int stop_bits);
        return (1 + data_bits + parity_en + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: pulses bit_end on the last cycle of every serial bit
// while run is high, and holds at zero while run is low.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_uart,
    input  logic clrn,
    input  logic run,
    output logic bit_end
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = run && (cnt == LAST);

    always_ff @(posedge clk_uart or negedge clrn) begin
        if (!clrn) begin
            cnt <= '0;
        end else if (!run || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits. txd/tx_busy/tx_done are registered; tx_ready is not.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int PARITY_EN    = UART_PARITY_EN,
    parameter int PARITY_ODD   = UART_PARITY_ODD,
    parameter int STOP_BITS    = UART_STOP_BITS
) (
    input  logic       clk_uart,
    input  logic       clrn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [7:0] DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_t state, state_next;
    logic [7:0]  shift_reg, shift_next;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic        parity_bit;
    logic        txd_next, busy_next, done_next;
    logic        bit_end;
    logic        accept;

    assign tx_ready = (state == IDLE);
    assign accept   = tx_valid && tx_ready;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_uart(clk_uart),
        .clrn    (clrn),
        .run     (state != IDLE),
        .bit_end (bit_end)
    );

    // The output registers are loaded with the value belonging to the state
    // being entered, so txd changes exactly on the bit boundary.
    always_ff @(posedge clk_uart or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            txd        <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            if (accept) begin
                parity_bit <= (^(tx_data & DATA_MASK)) ^ (PARITY_ODD != 0);
            end
            txd     <= txd_next;
            tx_busy <= busy_next;
            tx_done <= done_next;
        end
    end

    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = START;
                    shift_next = tx_data & DATA_MASK;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // bit_cnt is reused here to count stop bits.
                if (bit_end) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                bit_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        txd_next  = 1'b1;
        busy_next = (state_next != IDLE);
        done_next = (state == STOP) && (state_next == IDLE);
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
            PARITY:  txd_next = parity_bit;
            default: txd_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (default, odd parity, no parity, 1-clock
// bits with 5 data and 2 stop bits) checked cycle by cycle against a bit queue.
module tb_uart_tx;

    logic       clk_uart = 1'b0;
    logic       clrn;
    logic [3:0] tx_valid;
    logic [7:0] tx_data [4];
    wire  [3:0] tx_ready;
    wire  [3:0] txd;
    wire  [3:0] tx_busy;
    wire  [3:0] tx_done;

    int cpb_c [4] = '{16, 16, 16, 1};
    int db_c  [4] = '{8, 8, 8, 5};
    int pen_c [4] = '{1, 1, 0, 1};
    int odd_c [4] = '{0, 1, 0, 0};
    int sb_c  [4] = '{1, 1, 1, 2};

    int   tests = 0;
    int   fails = 0;
    logic exp_q[$];

    always #5 clk_uart = ~clk_uart;

    uart_tx u0 (
        .clk_uart(clk_uart), .clrn(clrn), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
        .tx_ready(tx_ready[0]), .txd(txd[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0])
    );

    uart_tx #(.PARITY_ODD(1)) u1 (
        .clk_uart(clk_uart), .clrn(clrn), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
        .tx_ready(tx_ready[1]), .txd(txd[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1])
    );

    uart_tx #(.PARITY_EN(0)) u2 (
        .clk_uart(clk_uart), .clrn(clrn), .tx_valid(tx_valid[2]), .tx_data(tx_data[2]),
        .tx_ready(tx_ready[2]), .txd(txd[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2])
    );

    uart_tx #(.CLKS_PER_BIT(1), .DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .clk_uart(clk_uart), .clrn(clrn), .tx_valid(tx_valid[3]), .tx_data(tx_data[3]),
        .tx_ready(tx_ready[3]), .txd(txd[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3])
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Queues the expected line bits, then presents the byte until accepted.
    task automatic applyStimulus(input int k, input logic [7:0] data, input bit hold);
        logic par;
        int   guard;
        par = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < db_c[k]; i++) begin
            exp_q.push_back(data[i]);
            par = par ^ data[i];
        end
        if (pen_c[k] != 0) exp_q.push_back(par ^ (odd_c[k] != 0));
        for (int i = 0; i < sb_c[k]; i++) exp_q.push_back(1'b1);
        tx_valid[k] = 1'b1;
        tx_data[k]  = data;
        guard = 0;
        while (!tx_ready[k] && guard < 1000) begin
            @(negedge clk_uart);
            guard++;
        end
        check($sformatf("u%0d ready_wait", k), tx_ready[k], 1'b1);
        @(posedge clk_uart);
        #1;
        if (!hold) tx_valid[k] = 1'b0;
        tx_data[k] = ~data;
    endtask

    // Walks the frame one cycle at a time from the accept edge, popping one
    // expected bit per bit period; ends on the cycle tx_done must be high.
    task automatic checkOutput(input int k);
        int   nbits;
        logic e;
        nbits = 1 + db_c[k] + pen_c[k] + sb_c[k];
        for (int b = 0; b < nbits; b++) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("[TB] FAIL u%0d queue: observed empty expected bit %0d", k, b);
                e = 1'b1;
            end else begin
                e = exp_q.pop_front();
            end
            for (int c = 0; c < cpb_c[k]; c++) begin
                @(negedge clk_uart);
                check($sformatf("u%0d bit%0d cyc%0d txd", k, b, c), txd[k], e);
                check($sformatf("u%0d bit%0d cyc%0d busy", k, b, c), tx_busy[k], 1'b1);
                check($sformatf("u%0d bit%0d cyc%0d ready", k, b, c), tx_ready[k], 1'b0);
                check($sformatf("u%0d bit%0d cyc%0d done", k, b, c), tx_done[k], 1'b0);
            end
        end
        @(negedge clk_uart);
        check($sformatf("u%0d end done", k), tx_done[k], 1'b1);
        check($sformatf("u%0d end busy", k), tx_busy[k], 1'b0);
        check($sformatf("u%0d end txd", k), txd[k], 1'b1);
        check($sformatf("u%0d end ready", k), tx_ready[k], 1'b1);
    endtask

    initial begin
        clrn     = 1'b0;
        tx_valid = '0;
        for (int k = 0; k < 4; k++) tx_data[k] = 8'h00;
        repeat (3) @(negedge clk_uart);
        clrn = 1'b1;

        repeat (50) begin
            @(negedge clk_uart);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("u%0d rst txd", k), txd[k], 1'b1);
                check($sformatf("u%0d rst ready", k), tx_ready[k], 1'b1);
                check($sformatf("u%0d rst busy", k), tx_busy[k], 1'b0);
                check($sformatf("u%0d rst done", k), tx_done[k], 1'b0);
            end
        end

        applyStimulus(0, 8'h55, 1'b0);
        checkOutput(0);

        applyStimulus(0, 8'hA7, 1'b0);
        checkOutput(0);
        applyStimulus(1, 8'hA7, 1'b0);
        checkOutput(1);
        applyStimulus(2, 8'hA7, 1'b0);
        checkOutput(2);

        // Back-to-back: valid stays high; 0xFF is waiting while 0x00 is sent.
        applyStimulus(0, 8'h00, 1'b1);
        tx_data[0] = 8'hFF;
        checkOutput(0);
        applyStimulus(0, 8'hFF, 1'b0);
        checkOutput(0);

        // Reset in the middle of data bit 3 of 0xA5 (a 0 on the line).
        applyStimulus(0, 8'hA5, 1'b0);
        repeat (4 * 16 + 9) @(negedge clk_uart);
        check("u0 pre-reset txd", txd[0], 1'b0);
        check("u0 pre-reset busy", tx_busy[0], 1'b1);
        #2 clrn = 1'b0;
        #1;
        check("u0 async rst txd", txd[0], 1'b1);
        check("u0 async rst busy", tx_busy[0], 1'b0);
        check("u0 async rst ready", tx_ready[0], 1'b1);
        check("u0 async rst done", tx_done[0], 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk_uart);
        clrn = 1'b1;
        @(negedge clk_uart);
        applyStimulus(0, 8'h3C, 1'b0);
        checkOutput(0);

        applyStimulus(3, 8'h1F, 1'b0);
        checkOutput(3);
        applyStimulus(3, 8'hE0, 1'b0);
        checkOutput(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
